mem_unit: RTL

Memory subsystem consumed by the Load/Store control FSMs: owns MAR, MDR, a word-addressed RAM array and the MFC (memory-function-complete) handshake. The FSM latches an address into MAR and data into MDR from the register bus, then raises MEM_EN/MEM_RW. This block performs the access after a fixed latency, loads MDR on reads, and pulses MFC so the FSM can advance.

---
 rtl/mem_unit_pkg.sv | 19 +
 rtl/mem_array.sv | 26 ++
 rtl/mem_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_unit_pkg.sv
// Shared types and defaults for the memory subsystem.
// State encoding, MEM_RW polarity and default widths.
package mem_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic RW_RD = 1'b1;
  localparam logic RW_WR = 1'b0;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LATENCY = 3;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read.
// rdata reflects the word at addr as of the previous edge.
module mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_unit.sv
// MAR/MDR, access sequencer and MFC handshake around mem_array.
// Accepts a request on the rising edge of MEM_EN, completes after LATENCY.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_write,
  input  logic              MDR_write,
  input  logic              MDR_read,
  input  logic              MEM_EN,
  input  logic              MEM_RW,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              MFC,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  mar_q, mar_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
  logic               rw_q, rw_d;
  logic               en_q, en_d;
  logic               req;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;

  assign req = MEM_EN & ~en_q;
  assign en_d = MEM_EN;

  // RAM read is registered, so point it at MAR while idle to have the
  // word ready by the completion edge even when LATENCY is 1.
  assign ram_addr = (state_q == S_IDLE) ? mar_q : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
    ram_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MAR_write) mar_d = bus_in[ADDR_W-1:0];
        if (MDR_write) mdr_d = bus_in;
        if (req) begin
          addr_d  = mar_q;
          rw_d    = MEM_RW;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (rw_q == RW_RD) mdr_d = ram_rdata;
          else ram_we = ~reset;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      rw_q    <= RW_WR;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(mdr_q),
    .rdata(ram_rdata)
  );

  assign bus_out = MDR_read ? mdr_q : '0;
  assign bus_oe  = MDR_read;
  assign MFC     = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);

endmodule
